// File: rtl/ram_sync_dp.sv
// ram_sync_dp: simple dual-port sync RAM with byte enables, read-during-write policy, registered read and clear engine
module ram_sync_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter bit RDW_MODE = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    writeOn,
  input  logic [ADDR_WIDTH-1:0]   wr_address,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    readOn,
  input  logic [ADDR_WIDTH-1:0]   rd_address,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  input  logic                    clear,
  output logic                    busy
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic valid_q, valid_d;
  logic pend_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wmask, rd_word, rd_merged;
  logic clr_go, wr_in, rd_in, wr_ok, rd_ok, rdw;
  for (genvar k = 0; k < NB; k++) begin : g_mask
    assign wmask[8*k+:8] = {8{byteEn[k]}};
  end
  // Request qualification, read data selection and next-state logic
  always_comb begin
    clr_go = state_q == IDLE && (clear || pend_q);
    wr_in = {1'b0, wr_address} < DEPTH_W;
    rd_in = {1'b0, rd_address} < DEPTH_W;
    wr_ok = state_q == IDLE && !clr_go && writeOn && wr_in;
    rd_ok = state_q == IDLE && !clr_go && readOn;
    rdw = RDW_MODE && wr_ok && wr_address == rd_address;
    rd_word = rd_in ? mem[rd_address] : '0;
    rd_merged = (rd_word & ~wmask) | (data_in & wmask);
    state_d = clr_go ? CLEAR : (state_q == CLEAR && ptr_q == LAST) ? IDLE : state_q;
    ptr_d = (state_q == CLEAR && ptr_q != LAST) ? ptr_q + 1'b1 : '0;
    valid_d = rd_ok;
    dout_d = !rd_ok ? dout_q : rdw ? rd_merged : rd_word;
  end
  // Control and read-port registers; a pending auto-clear is armed while in reset
  always_ff @(posedge clk) begin
    pend_q <= CLEAR_ON_RESET && !rst_n;
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
    end
  end
  // Storage array: clear sweep writes one word per cycle, otherwise byte-lane writes
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) mem[ptr_q] <= CLEAR_VALUE;
      else if (wr_ok) for (int k = 0; k < NB; k++) if (byteEn[k]) mem[wr_address][8*k+:8] <= data_in[8*k+:8];
    end
  end
  assign data_out = dout_q;
  assign data_valid = valid_q;
  assign busy = state_q == CLEAR;
endmodule

// File: tb/tb_ram_sync_dp.sv
// tb_ram_sync_dp: randomized and directed checks of ram_sync_dp against an array reference model
module tb_ram_sync_dp;
  localparam logic [31:0] CV = 32'hA5A5A5A5;
  localparam logic [31:0] CV2 = 32'h5A5A5A5A;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, we, re, clr;
  logic [4:0] wa, ra;
  logic [3:0] be;
  logic [31:0] din, dout0, dout1;
  logic val0, val1, busy0, busy1;
  logic rst2_n, we2, re2, clr2;
  logic [4:0] wa2, ra2;
  logic [3:0] be2;
  logic [31:0] din2, dout2;
  logic val2, busy2;
  logic [31:0] ref_mem [32];
  int mbusy;
  logic [31:0] e0, e1;
  logic ev;
  int passed = 0, total = 0;

  ram_sync_dp #(.RDW_MODE(1'b0), .CLEAR_VALUE(CV)) u0 (
    .clk(clk), .rst_n(rst_n), .writeOn(we), .wr_address(wa), .byteEn(be), .data_in(din),
    .readOn(re), .rd_address(ra), .data_out(dout0), .data_valid(val0), .clear(clr), .busy(busy0));
  ram_sync_dp #(.RDW_MODE(1'b1), .CLEAR_VALUE(CV)) u1 (
    .clk(clk), .rst_n(rst_n), .writeOn(we), .wr_address(wa), .byteEn(be), .data_in(din),
    .readOn(re), .rd_address(ra), .data_out(dout1), .data_valid(val1), .clear(clr), .busy(busy1));
  ram_sync_dp #(.DEPTH(20), .ADDR_WIDTH(5), .CLEAR_VALUE(CV2), .CLEAR_ON_RESET(1'b1)) u2 (
    .clk(clk), .rst_n(rst2_n), .writeOn(we2), .wr_address(wa2), .byteEn(be2), .data_in(din2),
    .readOn(re2), .rd_address(ra2), .data_out(dout2), .data_valid(val2), .clear(clr2), .busy(busy2));

  // One clock of stimulus on u0/u1 with the reference model advanced for the same edge
  task automatic step(input logic w, input logic [4:0] aw, input logic [3:0] b, input logic [31:0] d,
                      input logic r, input logic [4:0] ar, input logic c);
    logic [31:0] old;
    we = w; wa = aw; be = b; din = d; re = r; ra = ar; clr = c;
    ev = 1'b0;
    if (mbusy > 0) begin
      ref_mem[32 - mbusy] = CV;
      mbusy--;
    end else if (c) begin
      mbusy = 32;
    end else begin
      old = ref_mem[ar];
      if (w) for (int k = 0; k < 4; k++) if (b[k]) ref_mem[aw][8*k+:8] = d[8*k+:8];
      if (r) begin
        ev = 1'b1;
        e0 = old;
        e1 = ref_mem[ar];
      end
    end
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    mbusy = 0; e0 = '0; e1 = '0; ev = 1'b0;
  endtask

  task automatic test_reset();
    assert_reset();
    @(posedge clk); #1;
    total++; if (dout0 !== 32'h0) $display("FAIL reset_dout0: got %h want 0", dout0); else passed++;
    total++; if (dout1 !== 32'h0) $display("FAIL reset_dout1: got %h want 0", dout1); else passed++;
    total++; if (val0 !== 1'b0 || val1 !== 1'b0) $display("FAIL reset_valid: got %b%b want 00", val0, val1); else passed++;
    total++; if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL reset_busy: got %b%b want 00", busy0, busy1); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_clear();
    int hi;
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (busy0 !== 1'b1) $display("FAIL clear_busy_start: got %b want 1", busy0); else passed++;
    hi = 1;
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 4'hF, 32'hFFFFFFFF, 1, 5'(i), 0);
      if (busy0 === 1'b1) hi++;
      total++; if (val0 !== 1'b0) $display("FAIL clear_valid_low[%0d]: got %b want 0", i, val0); else passed++;
    end
    total++; if (hi !== 32) $display("FAIL clear_busy_len: got %0d want 32", hi); else passed++;
    total++; if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL clear_busy_end: got %b%b want 00", busy0, busy1); else passed++;
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 1, 5'(i), 0);
      total++; if (dout0 !== CV || val0 !== 1'b1) $display("FAIL clear_read[%0d]: got %h/%b want %h/1", i, dout0, val0, CV); else passed++;
    end
  endtask

  task automatic test_defaults();
    step(1, 3, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0);
    total++; if (dout0 !== 32'hDEADBEEF || val0 !== 1'b1) $display("FAIL dflt_read3: got %h/%b want deadbeef/1", dout0, val0); else passed++;
    total++; if (dout1 !== 32'hDEADBEEF) $display("FAIL dflt_read3_u1: got %h want deadbeef", dout1); else passed++;
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (val0 !== 1'b0 || dout0 !== 32'hDEADBEEF) $display("FAIL dflt_hold: got %h/%b want deadbeef/0", dout0, val0); else passed++;
    step(1, 7, 4'hF, 32'h0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0);
    total++; if (dout0 !== 32'h0 || val0 !== 1'b1) $display("FAIL dflt_read7: got %h/%b want 0/1", dout0, val0); else passed++;
  endtask

  task automatic test_byte_en();
    step(1, 5, 4'hF, 32'h11223344, 0, 0, 0);
    step(1, 5, 4'b0101, 32'hAABBCCDD, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0);
    total++; if (dout0 !== 32'h11BB33DD) $display("FAIL byte_en_u0: got %h want 11bb33dd", dout0); else passed++;
    total++; if (dout1 !== 32'h11BB33DD) $display("FAIL byte_en_u1: got %h want 11bb33dd", dout1); else passed++;
    step(1, 5, 4'h0, 32'hFFFFFFFF, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0);
    total++; if (dout0 !== 32'h11BB33DD) $display("FAIL byte_en_none: got %h want 11bb33dd", dout0); else passed++;
  endtask

  task automatic test_rdw();
    step(1, 9, 4'hF, 32'h1, 0, 0, 0);
    step(1, 9, 4'hF, 32'h2, 1, 9, 0);
    total++; if (dout0 !== 32'h1) $display("FAIL rdw_old: got %h want 1", dout0); else passed++;
    total++; if (dout1 !== 32'h2) $display("FAIL rdw_new: got %h want 2", dout1); else passed++;
    step(0, 0, 0, 0, 1, 9, 0);
    total++; if (dout0 !== 32'h2 || dout1 !== 32'h2) $display("FAIL rdw_after: got %h/%h want 2/2", dout0, dout1); else passed++;
    step(1, 9, 4'b0011, 32'hFFFFFFFF, 1, 9, 0);
    total++; if (dout1 !== 32'h0000FFFF || dout0 !== 32'h2) $display("FAIL rdw_partial: got %h/%h want 2/0000ffff", dout0, dout1); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 10; i < 14; i++) step(1, 5'(i), 4'hF, $urandom, 0, 0, 0);
    for (int i = 10; i < 14; i++) begin
      step(1, 5'(i + 10), 4'hF, $urandom, 1, 5'(i), 0);
      total++; if (val0 !== 1'b1 || dout0 !== e0) $display("FAIL b2b[%0d]: got %h/%b want %h/1", i, dout0, val0, e0); else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom), 4'($urandom), $urandom, 1'($urandom_range(0, 1)), 5'($urandom),
           1'($urandom_range(0, 63) == 0));
      total++;
      if (val0 !== ev || val1 !== ev || busy0 !== (mbusy > 0) || dout0 !== e0 || dout1 !== e1)
        $display("FAIL random[%0d]: got v%b%b b%b d%h/%h want v%b b%b d%h/%h", i, val0, val1, busy0, dout0, dout1, ev, mbusy > 0, e0, e1);
      else passed++;
    end
    for (int i = 0; i < 40 && mbusy > 0; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 10; i++) step(1, 5'(i), 4'hF, 32'h01010101 * i + 32'h1, 0, 0, 0);
    step(1, 20, 4'hF, 32'h12345678, 0, 0, 0);
    step(1, 10, 4'hF, 32'h0BADF00D, 0, 0, 0);
    step(0, 0, 0, 0, 1, 20, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (10) step(0, 0, 0, 0, 0, 0, 0);
    assert_reset();
    total++; if (busy0 !== 1'b0 || dout0 !== 32'h0 || val0 !== 1'b0) $display("FAIL midclr_reset: got b%b d%h v%b want b0 d0 v0", busy0, dout0, val0); else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 1, 5'(i), 0);
      total++; if (dout0 !== CV) $display("FAIL midclr_word[%0d]: got %h want %h", i, dout0, CV); else passed++;
    end
    step(0, 0, 0, 0, 1, 20, 0);
    total++; if (dout0 !== 32'h12345678) $display("FAIL midclr_addr20: got %h want 12345678", dout0); else passed++;
    step(0, 0, 0, 0, 1, 10, 0);
    total++; if (dout0 !== 32'h0BADF00D) $display("FAIL midclr_addr10: got %h want 0badf00d", dout0); else passed++;
  endtask

  task automatic test_depth20();
    int cnt;
    total++; if (busy2 !== 1'b0 || dout2 !== 32'h0 || val2 !== 1'b0) $display("FAIL d20_reset: got b%b d%h v%b want 0/0/0", busy2, dout2, val2); else passed++;
    rst2_n = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (busy2 === 1'b1) cnt++;
      if (i == 1 || i == 20) begin
        total++; if (busy2 !== 1'b1) $display("FAIL d20_busy_high[%0d]: got %b want 1", i, busy2); else passed++;
      end
      if (i == 21) begin
        total++; if (busy2 !== 1'b0) $display("FAIL d20_busy_low: got %b want 0", busy2); else passed++;
      end
    end
    total++; if (cnt !== 20) $display("FAIL d20_busy_len: got %0d want 20", cnt); else passed++;
    re2 = 1'b1; ra2 = 5'd0;
    @(posedge clk); #1;
    total++; if (dout2 !== CV2 || val2 !== 1'b1) $display("FAIL d20_read0: got %h/%b want %h/1", dout2, val2, CV2); else passed++;
    re2 = 1'b0; we2 = 1'b1; wa2 = 5'd25; be2 = 4'hF; din2 = 32'hCAFE;
    @(posedge clk); #1;
    we2 = 1'b0; re2 = 1'b1; ra2 = 5'd25;
    @(posedge clk); #1;
    total++; if (dout2 !== 32'h0 || val2 !== 1'b1) $display("FAIL d20_read25: got %h/%b want 0/1", dout2, val2); else passed++;
    ra2 = 5'd5;
    @(posedge clk); #1;
    total++; if (dout2 !== CV2) $display("FAIL d20_alias5: got %h want %h", dout2, CV2); else passed++;
    re2 = 1'b0; we2 = 1'b1; wa2 = 5'd19; din2 = 32'h00001234;
    @(posedge clk); #1;
    we2 = 1'b0; re2 = 1'b1; ra2 = 5'd19;
    @(posedge clk); #1;
    total++; if (dout2 !== 32'h00001234) $display("FAIL d20_read19: got %h want 00001234", dout2); else passed++;
    re2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0; wa = '0; ra = '0; be = '0; din = '0;
    rst2_n = 1'b0; we2 = 1'b0; re2 = 1'b0; clr2 = 1'b0; wa2 = '0; ra2 = '0; be2 = '0; din2 = '0;
    mbusy = 0; e0 = '0; e1 = '0; ev = 1'b0;
    test_reset();
    test_clear();
    test_defaults();
    test_byte_en();
    test_rdw();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    test_depth20();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
